// File: rtl/gate_chk_pkg.sv
// Shared state encoding, sizing constants and golden equation for the gate response checker.
package gate_chk_pkg;

  localparam int unsigned N_IN    = 5;
  localparam int unsigned NUM_VEC = 32;

  // State encoding kept as plain constants for compatibility with older tooling.
  typedef logic [2:0] gate_chk_state_t;
  localparam gate_chk_state_t ST_IDLE   = 3'd0;
  localparam gate_chk_state_t ST_DRIVE  = 3'd1;
  localparam gate_chk_state_t ST_SETTLE = 3'd2;
  localparam gate_chk_state_t ST_CHECK  = 3'd3;
  localparam gate_chk_state_t ST_DONE   = 3'd4;

  // vec[4]=x1 .. vec[0]=x5
  function automatic logic golden_z(input logic [N_IN-1:0] v);
    return ~((v[4] & v[3]) | (v[2] & v[1] & v[0]));
  endfunction

endpackage

// File: rtl/gate_golden_eq.sv
// Combinational golden reference: z = ~((x1&x2)|(x3&x4&x5)).
module gate_golden_eq
  import gate_chk_pkg::*;
(
  input  logic [N_IN-1:0] vec,
  output logic            z
);

  assign z = golden_z(vec);

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps all 32 input vectors into a gate under test and counts response mismatches.
// Optional first-fail capture is built only when GATE_CHK_FIRST_FAIL_EN is defined.
module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned N_IN          = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            dut_z,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [5:0]      err_cnt
`ifdef GATE_CHK_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
`endif
);

  import gate_chk_pkg::*;

  // The settle counter is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES.
  localparam logic [3:0] SettleLoad = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  gate_chk_state_t state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [5:0]      err_q, err_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pass_q, pass_d;
  logic            done_q, done_d;
  logic            gold_z;
  logic            sweep_start;
  logic            check_fail;

  gate_golden_eq u_golden (
    .vec (vec_q),
    .z   (gold_z)
  );

  assign sweep_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign check_fail  = (state_q == ST_CHECK) && (dut_z != gold_z);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          vec_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = SettleLoad;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        if (check_fail) begin
          err_d = err_q + 6'd1;
        end
        if (vec_q == {N_IN{1'b1}}) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == 6'd0);
        end else begin
          state_d = ST_DRIVE;
          vec_d   = vec_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign vec     = vec_q;
  assign err_cnt = err_q;
  assign pass    = pass_q;
  assign done    = done_q;
  assign busy    = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [N_IN-1:0] ff_vec_q, ff_vec_d;
  logic            ff_valid_q, ff_valid_d;

  always_comb begin
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    if (sweep_start) begin
      ff_vec_d   = '0;
      ff_valid_d = 1'b0;
    end else if (check_fail && !ff_valid_q) begin
      ff_vec_d   = vec_q;
      ff_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
    end
  end

  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;
`else
  logic unused_sweep_start;
  assign unused_sweep_start = sweep_start;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized self-checking bench for gate_response_checker with a cycle-level behavioural model.
module tb_gate_response_checker;

  localparam int S = 2;
  localparam int L = 32 * (S + 2);

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dut_z;
  logic [4:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_cnt;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [4:0] first_fail_vec;
  logic       first_fail_valid;
`endif

  always #5 clk = ~clk;

  gate_response_checker #(
    .SETTLE_CYCLES (S),
    .N_IN          (5)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .vec              (vec),
    .dut_z            (dut_z),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_cnt          (err_cnt)
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
`endif
  );

  // Gate under test: 0 = golden xor per-vector fault mask, 1 = stuck at 0, 2 = stuck at 1.
  int          mode = 0;
  logic [31:0] mask = '0;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;

  function automatic bit gold(input int v);
    bit x1, x2, x3, x4, x5;
    x1 = v[4]; x2 = v[3]; x3 = v[2]; x4 = v[1]; x5 = v[0];
    return !((x1 && x2) || (x3 && x4 && x5));
  endfunction

  function automatic bit resp(input int v, input int md, input logic [31:0] mk);
    if (md == 1) return 1'b0;
    if (md == 2) return 1'b1;
    return gold(v) ^ mk[v];
  endfunction

  assign dut_z = resp(int'(vec), mode, mask);

  function automatic int errs(input int n);
    int c = 0;
    for (int v = 0; v < n; v++) if (gold(v) != resp(v, mode, mask)) c++;
    return c;
  endfunction

  function automatic int first_mis(input int n);
    for (int v = 0; v < n; v++) if (gold(v) != resp(v, mode, mask)) return v;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: phase 0 idle, 1 sweeping, 2 finished; m_k counts cycles since the start edge.
  int m_ph = 0;
  int m_k  = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0;
      m_k  <= 0;
    end else if (m_ph != 1 && start) begin
      m_ph <= 1;
      m_k  <= 0;
    end else if (m_ph == 1) begin
      m_k <= m_k + 1;
      if (m_k == L - 1) m_ph <= 2;
    end else if (m_ph == 2 && m_k <= L) begin
      m_k <= m_k + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    int n, ev, eb, ed, ep, ee, f;
    forever begin
      @(posedge clk);
      #1;
      ev = 0; eb = 0; ed = 0; ep = 0; ee = 0; f = -1;
      if (m_ph == 1) begin
        n  = m_k / (S + 2);
        ev = n;
        eb = 1;
        ee = errs(n);
        f  = first_mis(n);
      end else if (m_ph == 2) begin
        ev = 31;
        ed = (m_k == L) ? 1 : 0;
        ee = errs(32);
        ep = (ee == 0) ? 1 : 0;
        f  = first_mis(32);
      end
      chk("vec", int'(vec), ev);
      chk("busy", int'(busy), eb);
      chk("done", int'(done), ed);
      chk("pass", int'(pass), ep);
      chk("err_cnt", int'(err_cnt), ee);
`ifdef GATE_CHK_FIRST_FAIL_EN
      chk("ff_valid", int'(first_fail_valid), (f >= 0) ? 1 : 0);
      chk("ff_vec", int'(first_fail_vec), (f >= 0) ? f : 0);
`endif
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < L + 20 && !done; i++) @(negedge clk);
    if (!done) chk({name, "_done_timeout"}, 0, 1);
  endtask

  // Called at a negedge; leaves the bench at the negedge where done is seen.
  // exp_err < 0 skips literal checks; exp_ff < 0 expects no captured failure.
  task automatic run_sweep(input string name, input int md, input logic [31:0] mk,
                           input int exp_err, input int exp_ff);
    int c0;
    mode  = md;
    mask  = mk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    wait_done(name);
    chk({name, "_latency"}, cyc - c0, 128);
    if (exp_err >= 0) begin
      chk({name, "_err"}, int'(err_cnt), exp_err);
      chk({name, "_pass"}, int'(pass), (exp_err == 0) ? 1 : 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
      chk({name, "_ff_valid"}, int'(first_fail_valid), (exp_ff >= 0) ? 1 : 0);
      if (exp_ff >= 0) chk({name, "_ff_vec"}, int'(first_fail_vec), exp_ff);
`endif
    end
  endtask

  initial begin
    int c0;
    int saw_done;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err_cnt), 0);
    chk("reset_vec", int'(vec), 0);

    run_sweep("correct", 0, 32'h0, 0, -1);
    run_sweep("stuck0", 1, 32'h0, 21, 0);      // restarts in the DONE cycle
    run_sweep("stuck1", 2, 32'h0, 11, 7);
    run_sweep("inverted", 0, 32'hFFFF_FFFF, 32, 0);
    for (int r = 0; r < 3; r++) run_sweep("random", 0, $urandom, -1, -1);
    repeat (4) @(negedge clk);

    // Start pulses mid-sweep must be ignored.
    mode = 0; mask = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    for (int i = 0; i < L && vec != 5'd10; i++) @(negedge clk);
    chk("midstart_reach10", int'(vec), 10);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("midstart");
    chk("midstart_latency", cyc - c0, 128);
    chk("midstart_err", int'(err_cnt), 0);
    repeat (3) @(negedge clk);

    // Reset mid-sweep at vec 17.
    mode = 0; mask = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < L && vec != 5'd17; i++) @(negedge clk);
    chk("rst_reach17", int'(vec), 17);
    rst_n = 1'b0;
    #1;
    chk("rst_vec", int'(vec), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < L + 20; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    chk("rst_no_resume", saw_done, 0);
    run_sweep("after_rst", 0, 32'h0, 0, -1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
